rr_mux_arbiter: RTL and testbench
=================================

// Module: rr_mux_arbiter
// PURPOSE
//   Round-robin arbiter that shares the 8:1 data mux among N_REQ requesters.
//   Each requester raises Req and holds it while it owns the mux.
//   The block drives the mux Select, a one-hot Grant and Valid.
//   It forces rotation after MAX_HOLD cycles so no requester starves the rest.
// PARAMETERS
//   N_REQ     8    number of requesters / mux inputs (power of 2)
//   SEL_W     3    select width, log2(N_REQ)
//   MAX_HOLD  15   max consecutive cycles one grant may last (>=1)
// PORTS
//   Clk     in   1       single clock, rising edge
//   Rst_n   in   1       synchronous reset, active-low
//   Req     in   N_REQ   request per requester, level
//   Done    in   N_REQ   release pulse per requester; honoured only for granted index
//   In      in   N_REQ   data bit per requester (mux data inputs)
//   Grant   out  N_REQ   one-hot grant, registered
//   Select  out  SEL_W   index of granted requester, registered
//   Valid   out  1       a grant is active, registered
//   Out     out  1       In[Select] when Valid, else 0 (combinational)
// BEHAVIOUR
//   Reset (Rst_n=0 at a Clk edge, overrides all, incl. mid-grant):
//     Grant=0, Select=0, Valid=0, Out=0, ptr=0, hold_cnt=0, state=IDLE.
//   FSM states IDLE and GRANT.
//   IDLE: if |Req, choose the first set bit searching ptr, ptr+1 .. wrapping mod N_REQ.
//     Next edge: state=GRANT, Select=idx, Grant=1<<idx, Valid=1, hold_cnt=0.
//     Latency Req->Grant is 1 cycle. With no Req, stay IDLE and keep outputs at 0.
//   GRANT: hold_cnt increments each cycle, saturating at MAX_HOLD-1.
//     Release when any of these holds:
//       Done[Select]=1
//       Req[Select]=0
//       hold_cnt==MAX_HOLD-1
//   On release: ptr <= Select+1 (wraps 7->0).
//     Search Req from Select+1 with wrap.
//       Winner found: grant it on the same edge, with no idle bubble and hold_cnt=0.
//       Release was by Done/Req drop: the old index is excluded from this search.
//       Release was by timeout: the old index is eligible, but only as the last candidate.
//       No winner: state=IDLE, Grant=0, Valid=0.
//   Done on a non-granted index is ignored.
//   Req changes on non-granted lines never disturb the current grant.
//   MAX_HOLD=1: every grant lasts exactly 1 cycle (pure rotation).
//   Invariants: Grant is one-hot or zero; Grant==0 iff Valid==0;
//     Grant==(1<<Select) whenever Valid=1.
//   Out follows Select in the same cycle through the mux; it is 0 when Valid=0.
// STRUCTURE
//   Shared package rr_arb_pkg:
//     state localparams ST_IDLE=1'b0, ST_GRANT=1'b1;
//     default N_REQ / SEL_W / MAX_HOLD constants.
//   Priority search is a function "next_req(req, start)" returning {found, idx};
//     it lives in the package.
//   One sub-module: mux8to1 (In, Select, mux_out); Out = Valid & mux_out.
//   The arbiter body holds FSM, ptr, hold_cnt and registered outputs only.
// TESTING
//   1 Reset: Rst_n=0 for 2 cycles with Req=8'hFF.
//     -> Grant=0, Select=0, Valid=0, Out=0; first grant goes to idx 0 one cycle after release.
//   2 Single requester: Req=8'b0010_0000, In=8'hF0.
//     -> next cycle Select=5, Grant=8'h20, Valid=1, Out=In[5];
//     -> pulse Done[5] -> IDLE next cycle, ptr=6.
//   3 Rotation: Req=8'hFF, Done pulsed on each grant.
//     -> Select sequence 0,1,2,...,7,0 with no idle cycles between grants.
//   4 Timeout: Req=8'h03 held, no Done, MAX_HOLD=15.
//     -> idx0 holds exactly 15 cycles, then idx1 for 15, then idx0 again.
//   5 Stray/drop: Done[3] pulsed while idx1 granted -> no change;
//     -> drop Req[1] -> release next edge, grant moves to the next pending index.
//   6 Reset mid-grant: Rst_n=0 while Select=6 -> all outputs 0 next edge, ptr=0.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// +--------------------------------------------------------------------+
// | rr_arb_pkg: shared constants, FSM encodings and the round-robin    |
// | priority search used by the rr_mux_arbiter block.                  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package rr_arb_pkg;

   localparam int N_REQ        = 8;
   localparam int SEL_W        = 3;
   localparam int MAX_HOLD_DEF = 15;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   // Returns {found, idx}: first set bit of req at or after start, wrapping.
   // Scanning downward lets the smallest offset from start overwrite last.
   function automatic logic [SEL_W:0] next_req(input logic [N_REQ-1:0] req,
                                                input logic [SEL_W-1:0] start);
      logic [SEL_W:0]   res;
      logic [SEL_W-1:0] idx;
      res = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = start + SEL_W'(i);
         if (req[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_mux_arbiter_if.sv
// +--------------------------------------------------------------------+
// | rr_mux_arbiter_if: request/grant/data bundle between requesters    |
// | (master) and the arbiter (slave).                                  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface rr_mux_arbiter_if;
   import rr_arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] done;
   logic [N_REQ-1:0] data;
   logic [N_REQ-1:0] grant;
   logic [SEL_W-1:0] select;
   logic             valid;
   logic             out;

   modport master (
      output req, done, data,
      input  grant, select, valid, out
   );

   modport slave (
      input  req, done, data,
      output grant, select, valid, out
   );

endinterface

`default_nettype wire

// File: rtl/rr_mux_arbiter_mux8to1.sv
// +--------------------------------------------------------------------+
// | mux8to1: shared data mux, one bit per requester.                   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mux8to1
   import rr_arb_pkg::*;
(
   input  logic [N_REQ-1:0] data_in,
   input  logic [SEL_W-1:0] select,
   output logic             mux_out
);

   assign mux_out = data_in[select];

endmodule

`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
// +--------------------------------------------------------------------+
// | rr_mux_arbiter: round-robin owner of the 8:1 data mux with a       |
// | bounded hold time per grant.                                       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_mux_arbiter
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   rr_mux_arbiter_if.slave bus
);

   localparam int              HC_W      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] ptr_nxt;
   logic [SEL_W-1:0] sel_nxt;
   logic [SEL_W-1:0] sel_inc;
   logic [HC_W-1:0]  hold_cnt;
   logic [HC_W-1:0]  hold_nxt;
   logic [N_REQ-1:0] grant_nxt;
   logic [N_REQ-1:0] search_req;
   logic [SEL_W:0]   pick;
   logic             valid_nxt;
   logic             timeout;
   logic             by_done;
   logic             release_grant;
   logic             mux_out;

   mux8to1 u_mux (
      .data_in (bus.data),
      .select  (bus.select),
      .mux_out (mux_out)
   );

   assign bus.out = bus.valid & mux_out;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         hold_cnt   <= '0;
         bus.select <= '0;
         bus.grant  <= '0;
         bus.valid  <= 1'b0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         hold_cnt   <= hold_nxt;
         bus.select <= sel_nxt;
         bus.grant  <= grant_nxt;
         bus.valid  <= valid_nxt;
      end
   end

   always_comb begin
      timeout       = (hold_cnt == HOLD_LAST);
      by_done       = bus.done[bus.select];
      release_grant = by_done || !bus.req[bus.select] || timeout;
      sel_inc       = bus.select + SEL_W'(1);
      state_nxt     = state;
      ptr_nxt       = ptr;
      sel_nxt       = bus.select;
      hold_nxt      = hold_cnt;
      search_req    = bus.req;
      pick          = '0;

      case (state)
         ST_IDLE: begin
            hold_nxt = '0;
            sel_nxt  = '0;
            pick     = next_req(bus.req, ptr);
            if (pick[SEL_W]) begin
               state_nxt = ST_GRANT;
               sel_nxt   = pick[SEL_W-1:0];
            end
         end
         default: begin
            if (release_grant) begin
               // Searching from select+1 puts the old owner last, which is
               // exactly where a timed-out owner may still win.
               ptr_nxt  = sel_inc;
               hold_nxt = '0;
               if (by_done) begin
                  search_req[bus.select] = 1'b0;
               end
               pick = next_req(search_req, sel_inc);
               if (pick[SEL_W]) begin
                  sel_nxt = pick[SEL_W-1:0];
               end else begin
                  state_nxt = ST_IDLE;
                  sel_nxt   = '0;
               end
            end else if (hold_cnt != HOLD_LAST) begin
               hold_nxt = hold_cnt + HC_W'(1);
            end
         end
      endcase
   end

   always_comb begin
      valid_nxt = (state_nxt == ST_GRANT);
      grant_nxt = valid_nxt ? (N_REQ'(1) << sel_nxt) : '0;
   end

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_rr_mux_arbiter: directed stimulus against a behavioural model,  |
// | two instances (MAX_HOLD=15 and MAX_HOLD=1) on shared inputs.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_rr_mux_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] done;
   logic [7:0] data;
   int         tests;
   int         fails;
   bit         cmp_en;

   int m_valid [2];
   int m_sel   [2];
   int m_ptr   [2];
   int m_hold  [2];

   rr_mux_arbiter_if ifa ();
   rr_mux_arbiter_if ifb ();

   assign ifa.req  = req;
   assign ifa.done = done;
   assign ifa.data = data;
   assign ifb.req  = req;
   assign ifb.done = done;
   assign ifb.data = data;

   rr_mux_arbiter #(.MAX_HOLD(15)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   rr_mux_arbiter #(.MAX_HOLD(1))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Reference: scan requesters in round-robin order from the pointer.
   always @(posedge clk) begin : model
      int  mh;
      int  j;
      int  cand;
      bit  dd;
      bit  rel;
      for (int k = 0; k < 2; k++) begin
         mh = (k == 0) ? 15 : 1;
         if (!rst_n) begin
            m_valid[k] = 0; m_sel[k] = 0; m_ptr[k] = 0; m_hold[k] = 0;
         end else if (m_valid[k] == 0) begin
            cand = -1;
            for (int i = 0; i < 8; i++) begin
               j = (m_ptr[k] + i) % 8;
               if (cand < 0 && req[j]) cand = j;
            end
            if (cand >= 0) begin
               m_valid[k] = 1; m_sel[k] = cand; m_hold[k] = 0;
            end
         end else begin
            dd  = done[m_sel[k]] || !req[m_sel[k]];
            rel = dd || (m_hold[k] == mh - 1);
            if (rel) begin
               cand = -1;
               for (int i = 1; i <= 8; i++) begin
                  j = (m_sel[k] + i) % 8;
                  if (cand < 0 && req[j] && !(i == 8 && dd)) cand = j;
               end
               m_ptr[k]  = (m_sel[k] + 1) % 8;
               m_hold[k] = 0;
               if (cand >= 0) begin
                  m_sel[k] = cand;
               end else begin
                  m_valid[k] = 0; m_sel[k] = 0;
               end
            end else if (m_hold[k] < mh - 1) begin
               m_hold[k] = m_hold[k] + 1;
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      logic [7:0] eg;
      logic       eo;
      if (cmp_en) begin
         for (int k = 0; k < 2; k++) begin
            eg = (m_valid[k] != 0) ? (8'd1 << m_sel[k]) : 8'd0;
            eo = (m_valid[k] != 0) ? data[m_sel[k]] : 1'b0;
            if (k == 0) begin
               chk("a_grant",  32'(ifa.grant),  32'(eg));
               chk("a_select", 32'(ifa.select), 32'(m_sel[k]));
               chk("a_valid",  32'(ifa.valid),  32'(m_valid[k]));
               chk("a_out",    32'(ifa.out),    32'(eo));
            end else begin
               chk("b_grant",  32'(ifb.grant),  32'(eg));
               chk("b_select", 32'(ifb.select), 32'(m_sel[k]));
               chk("b_valid",  32'(ifb.valid),  32'(m_valid[k]));
               chk("b_out",    32'(ifb.out),    32'(eo));
            end
         end
      end
   end

   initial begin
      tests  = 0;
      fails  = 0;
      cmp_en = 1'b0;
      rst_n  = 1'b0;
      req    = 8'hFF;
      done   = 8'h00;
      data   = 8'hF0;

      // Reset held two cycles with every request raised
      step();
      step();
      cmp_en = 1'b1;
      chk("rst_grant",  32'(ifa.grant),  32'h0);
      chk("rst_select", 32'(ifa.select), 32'h0);
      chk("rst_valid",  32'(ifa.valid),  32'h0);
      chk("rst_out",    32'(ifa.out),    32'h0);
      rst_n = 1'b1;
      step();
      chk("first_sel",   32'(ifa.select), 32'h0);
      chk("first_valid", 32'(ifa.valid),  32'h1);

      // Single requester, release with Done, pointer moves past it
      rst_n = 1'b0; step();
      rst_n = 1'b1; req = 8'b0010_0000; step();
      chk("single_sel",   32'(ifa.select), 32'h5);
      chk("single_grant", 32'(ifa.grant),  32'h20);
      chk("single_out",   32'(ifa.out),    32'h1);
      req = 8'h00; done = 8'h20; step();
      chk("single_idle", 32'(ifa.valid), 32'h0);
      done = 8'h00; req = 8'hFF; step();
      chk("ptr_after_done", 32'(ifa.select), 32'h6);

      // Rotation with Done on every grant
      data = 8'hA5;
      rst_n = 1'b0; step();
      rst_n = 1'b1; step();
      chk("rot_sel0", 32'(ifa.select), 32'h0);
      for (int i = 1; i <= 8; i++) begin
         done = 8'd1 << ((i - 1) % 8);
         step();
         chk("rot_sel",   32'(ifa.select), 32'(i % 8));
         chk("rot_valid", 32'(ifa.valid),  32'h1);
      end
      done = 8'h00;

      // Timeout: two requesters, no Done
      data  = 8'h02;
      rst_n = 1'b0; req = 8'h03; step();
      rst_n = 1'b1; step();
      chk("to_a_start", 32'(ifa.select), 32'h0);
      chk("to_b_start", 32'(ifb.select), 32'h0);
      step();
      chk("to_b_rot", 32'(ifb.select), 32'h1);
      repeat (13) step();
      chk("to_a_hold0", 32'(ifa.select), 32'h0);
      step();
      chk("to_a_sw1", 32'(ifa.select), 32'h1);
      repeat (14) step();
      chk("to_a_hold1", 32'(ifa.select), 32'h1);
      step();
      chk("to_a_sw0", 32'(ifa.select), 32'h0);

      // Stray Done then dropped Req
      data  = 8'h0F;
      rst_n = 1'b0; req = 8'h0A; step();
      rst_n = 1'b1; step();
      chk("stray_start", 32'(ifa.select), 32'h1);
      done = 8'h08; step();
      done = 8'h00;
      chk("stray_keep", 32'(ifa.select), 32'h1);
      req = 8'h08; step();
      chk("drop_move", 32'(ifa.select), 32'h3);

      // Reset in the middle of a grant
      rst_n = 1'b0; req = 8'h40; step();
      rst_n = 1'b1; step();
      chk("mid_sel6", 32'(ifa.select), 32'h6);
      rst_n = 1'b0; step();
      chk("mid_grant", 32'(ifa.grant),  32'h0);
      chk("mid_valid", 32'(ifa.valid),  32'h0);
      chk("mid_sel",   32'(ifa.select), 32'h0);
      chk("mid_out",   32'(ifa.out),    32'h0);
      rst_n = 1'b1; req = 8'hFF; step();
      chk("mid_ptr0", 32'(ifa.select), 32'h0);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
